// File: rtl/procyon_dcache_victim_buffer.sv
// Victim buffer for the data cache: queues dirty evicted lines in order and
// writes each one back as a beat-serialized burst, with a lookup port for the miss path.
module procyon_dcache_victim_buffer #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_DC_LINE_SIZE  = 32,
  parameter int OPTN_VB_DEPTH      = 4,
  parameter int OPTN_WB_DATA_WIDTH = 32,
  parameter int DC_LINE_WIDTH      = OPTN_DC_LINE_SIZE * 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_victim_valid,
  input  logic                          i_victim_dirty,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_victim_addr,
  input  logic [DC_LINE_WIDTH-1:0]      i_victim_data,
  output logic                          o_vb_full,
  output logic                          o_vb_empty,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_lookup_addr,
  output logic                          o_lookup_hit,
  output logic [DC_LINE_WIDTH-1:0]      o_lookup_data,
  output logic                          o_wb_req,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_wb_addr,
  output logic [OPTN_WB_DATA_WIDTH-1:0] o_wb_data,
  output logic                          o_wb_last,
  input  logic                          i_wb_ack
);

  localparam int BEATS      = DC_LINE_WIDTH / OPTN_WB_DATA_WIDTH;
  localparam int BEAT_BYTES = OPTN_WB_DATA_WIDTH / 8;
  localparam int OFFSET_W   = $clog2(OPTN_DC_LINE_SIZE);
  localparam int TAG_W      = OPTN_ADDR_WIDTH - OFFSET_W;
  localparam int PTR_W      = $clog2(OPTN_VB_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [OPTN_VB_DEPTH-1:0] r_valid;
  logic [TAG_W-1:0]         r_tag  [OPTN_VB_DEPTH];
  logic [DC_LINE_WIDTH-1:0] r_data [OPTN_VB_DEPTH];
  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [CNT_W-1:0]         r_count;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [TAG_W-1:0]         r_burst_tag;
  logic [DC_LINE_WIDTH-1:0] r_burst_data;
  logic [BEAT_W-1:0]        r_beat;

  logic                     w_enq;
  logic                     w_pop;
  logic                     w_send;
  logic                     w_last;
  logic [TAG_W-1:0]         w_lookup_tag;
  logic [PTR_W-1:0]         w_lk_idx;

  assign o_vb_full  = (r_count == CNT_W'(OPTN_VB_DEPTH));
  assign o_vb_empty = (r_count == '0);

  assign w_send = (r_state == SEND);
  assign w_last = (r_beat == BEAT_W'(BEATS - 1));
  assign w_enq  = i_victim_valid & i_victim_dirty & ~o_vb_full;
  assign w_pop  = w_send & i_wb_ack & w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload carries no reset; r_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_tag[r_tail]  <= i_victim_addr[OPTN_ADDR_WIDTH-1:OFFSET_W];
      r_data[r_tail] <= i_victim_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!o_vb_empty) w_next_state = SEND;
      SEND:    if (i_wb_ack && w_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_burst_tag  <= '0;
      r_burst_data <= '0;
      r_beat       <= '0;
    end else if (r_state == IDLE && !o_vb_empty) begin
      r_burst_tag  <= r_tag[r_head];
      r_burst_data <= r_data[r_head];
      r_beat       <= '0;
    end else if (w_send && i_wb_ack && !w_last) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  always_comb begin
    o_wb_req  = w_send;
    o_wb_last = w_send & w_last;
    o_wb_addr = '0;
    o_wb_data = '0;
    if (w_send) begin
      o_wb_addr = {r_burst_tag, {OFFSET_W{1'b0}}}
                + OPTN_ADDR_WIDTH'(r_beat) * OPTN_ADDR_WIDTH'(BEAT_BYTES);
      o_wb_data = r_burst_data[r_beat*OPTN_WB_DATA_WIDTH +: OPTN_WB_DATA_WIDTH];
    end
  end

  // Walk entries oldest-to-youngest from head so the youngest match overwrites older ones.
  assign w_lookup_tag = i_lookup_addr[OPTN_ADDR_WIDTH-1:OFFSET_W];

  always_comb begin
    o_lookup_hit  = 1'b0;
    o_lookup_data = '0;
    w_lk_idx      = '0;
    for (int unsigned i = 0; i < OPTN_VB_DEPTH; i++) begin
      w_lk_idx = r_head + PTR_W'(i);
      if (r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lookup_tag)) begin
        o_lookup_hit  = 1'b1;
        o_lookup_data = r_data[w_lk_idx];
      end
    end
  end

endmodule

// File: doc/procyon_dcache_victim_buffer.md
Name: procyon_dcache_victim_buffer

Overview:
- Receives victim lines evicted by the data cache on its victim output interface.
- Queues dirty victims in a small in-order buffer.
- Writes each queued line back to memory as a serialized burst over a beat-level req/ack interface.
- Provides a combinational lookup so the miss path can find a line that is still waiting for writeback.

Parameters:
- OPTN_DATA_WIDTH, 32, core data word width (passed through, documents the cache word size)
- OPTN_ADDR_WIDTH, 32, address width
- OPTN_DC_LINE_SIZE, 32, cache line size in bytes
- OPTN_VB_DEPTH, 4, number of buffer entries (power of 2, at least 2)
- OPTN_WB_DATA_WIDTH, 32, writeback bus beat width in bits (power of 2, divides the line width)
- DC_LINE_WIDTH, OPTN_DC_LINE_SIZE*8, line width in bits (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_victim_valid  in  1  victim line present this cycle
- i_victim_dirty  in  1  victim line is dirty
- i_victim_addr  in  OPTN_ADDR_WIDTH  victim line address
- i_victim_data  in  DC_LINE_WIDTH  victim line data
- o_vb_full  out  1  all entries occupied
- o_vb_empty  out  1  no entries occupied
- i_lookup_addr  in  OPTN_ADDR_WIDTH  address to search for
- o_lookup_hit  out  1  a valid entry matches the line address of i_lookup_addr
- o_lookup_data  out  DC_LINE_WIDTH  line data of the youngest matching entry
- o_wb_req  out  1  a writeback beat is presented
- o_wb_addr  out  OPTN_ADDR_WIDTH  byte address of the presented beat
- o_wb_data  out  OPTN_WB_DATA_WIDTH  data of the presented beat
- o_wb_last  out  1  presented beat is the final beat of the line
- i_wb_ack  in  1  memory accepts the presented beat this cycle

Behaviour:
- Derived values: BEATS = DC_LINE_WIDTH/OPTN_WB_DATA_WIDTH; BEAT_BYTES = OPTN_WB_DATA_WIDTH/8; OFFSET_W = clog2(OPTN_DC_LINE_SIZE).
- Reset values: o_wb_req=0, o_wb_addr=0, o_wb_data=0, o_wb_last=0, o_vb_full=0, o_vb_empty=1, o_lookup_hit=0, o_lookup_data=0.
- Reset is asynchronous. Asserting rst mid-burst drops o_wb_req at once, invalidates all entries, and returns the FSM to IDLE. Data in flight is discarded.
- Storage is a circular FIFO: head pointer, tail pointer, and count of width clog2(OPTN_VB_DEPTH)+1. Pointers wrap modulo OPTN_VB_DEPTH.
- o_vb_full = (count==OPTN_VB_DEPTH). o_vb_empty = (count==0). Both are driven from registered count.
- Enqueue:
  - Condition: i_victim_valid & i_victim_dirty & !o_vb_full, evaluated on the rising edge.
  - Stores the address with offset bits forced to 0, plus the full line.
  - A clean victim (dirty=0) is never stored.
  - A victim presented while full is ignored. Upstream must stall on o_vb_full.
  - There is no same-cycle bypass: a pop in the same cycle does not let a full buffer accept.
- Simultaneous enqueue and pop: count is unchanged, both pointers advance.
- Duplicate line address: a new entry is created. Entries drain oldest-first, so memory ends with the youngest data.
- Drain FSM:
  - IDLE:
    - If !empty, copy the head entry into the burst registers, set beat=0, go to SEND.
    - o_wb_req=0.
  - SEND:
    - o_wb_req=1.
    - o_wb_addr = line_addr + beat*BEAT_BYTES.
    - o_wb_data = line bits [beat*W +: W], where W = OPTN_WB_DATA_WIDTH.
    - o_wb_last = (beat==BEATS-1).
    - Address and data hold stable while i_wb_ack=0.
    - On i_wb_ack with !o_wb_last: beat increments.
    - On i_wb_ack with o_wb_last: pop the head (valid cleared, head advances), go to IDLE.
  - There is one idle cycle between consecutive lines.
- Lookup:
  - Combinational. Compares i_lookup_addr[ADDR-1:OFFSET_W] against every valid entry.
  - Includes the entry currently draining until its last beat is acked.
  - With several matches, the entry nearest the tail (youngest) wins.
  - o_lookup_data = 0 when there is no hit.
- A lookup and an enqueue in the same cycle do not see the new entry until the next cycle.

Test Plan:
- Enqueue dirty victim addr 0x00001047, data words W0..W7=0x11111111*(i+1), with ack always 1.
  - Required: 8 beats, o_wb_addr 0x1040, 0x1044, ... 0x105C, o_wb_data W0..W7, o_wb_last only on the 0x105C beat.
  - Required: o_vb_empty=1 the cycle after the last ack.
- Enqueue clean victim addr 0x2000 -> o_vb_empty stays 1 and o_wb_req never asserts.
- Hold ack=0 and enqueue lines 0x3000, 0x3020, 0x3040, 0x3060.
  - Required: o_vb_full=1; a 5th victim 0x3080 is ignored.
  - Release ack -> lines drain in order 0x3000 through 0x3060, 32 beats total; 0x3080 is never written.
- Enqueue 0x4000 (data A) then 0x4000 (data B) with ack=0; lookup 0x4014.
  - Required: o_lookup_hit=1, o_lookup_data=B. Lookup 0x5000 gives hit=0, data=0.
- During beat 2 of a burst, hold ack low for 3 cycles -> o_wb_addr, o_wb_data and o_wb_req hold constant; beat 3 follows the ack.
- Assert rst during beat 3 with 2 entries queued -> o_wb_req=0 in the same cycle, o_vb_empty=1, o_lookup_hit=0; no further beats after release.
